// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//   Memory-side refill engine for a 4-set direct-mapped data cache with
//   4 x DATA_WIDTH-bit words per block. On a miss it fetches the aligned
//   16-byte block as four word reads, collects the returns through a
//   latency-matched tag pipe and presents the block on d0..d3 with a
//   one-cycle refill_valid pulse.
//
// Optional feature macro: CRITICAL_WORD_FIRST_EN
//   defined   : reads start at the missed word and wrap (start, start+1, ...);
//               crit_valid/crit_data report the first returned word early.
//   undefined : reads are issued in order 0,1,2,3; no crit_* ports.
//
// Parameters
//   DATA_WIDTH  : word width of memory data and d0..d3
//   ADDR_WIDTH  : byte-address width (>= 5)
//   MEM_LATENCY : cycles from mem_rd_en to mem_rdata valid (1..4)
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   miss_req      : cache miss request, level, held until refill_valid
//   miss_addr     : missing byte address, sampled only while idle
//   busy          : refill in progress
//   mem_rd_en     : data-memory read strobe
//   mem_addr      : word-aligned read address
//   mem_rdata     : read data, valid MEM_LATENCY cycles after mem_rd_en
//   d0..d3        : block words at byte offsets 0x0/0x4/0x8/0xC
//   refill_valid  : one-cycle pulse, d0..d3 hold a complete block
//   crit_valid    : critical-word-ready pulse (feature only)
//   crit_data     : critical word (feature only)
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3,
  output logic                  refill_valid
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data
`endif
);

  localparam int unsigned WORDS  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BLK_W  = ADDR_WIDTH - 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        base_q, base_d;
  logic [IDX_W-1:0]        cap_q, cap_d;
  logic [IDX_W-1:0]        word_d;

  // Tag pipe: one entry per cycle, valid bit plus the word index in flight.
  logic                    pv_q [MEM_LATENCY];
  logic                    pv_d [MEM_LATENCY];
  logic [IDX_W-1:0]        pw_q [MEM_LATENCY];
  logic [IDX_W-1:0]        pw_d [MEM_LATENCY];

  logic [DATA_WIDTH-1:0]   dw_q [WORDS];
  logic [DATA_WIDTH-1:0]   dw_d [WORDS];

  logic                    busy_q, busy_d;
  logic                    rd_q, rd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rv_q, rv_d;

  logic                    cap_hit;
  logic [IDX_W-1:0]        cap_word;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]        start_q, start_d;
  logic                    cv_q, cv_d;
  logic [DATA_WIDTH-1:0]   cd_q, cd_d;
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[1:0];
`else
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[3:0];
`endif

  // A return is captured in the cycle its tag leaves the last pipe stage.
  assign cap_hit  = pv_q[MEM_LATENCY-1];
  assign cap_word = pw_q[MEM_LATENCY-1];

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    cap_d   = cap_q;
    dw_d    = dw_q;
    addr_d  = addr_q;
    word_d  = '0;
`ifdef CRITICAL_WORD_FIRST_EN
    start_d = start_q;
    cv_d    = 1'b0;
    cd_d    = cd_q;
`endif

    // The read launched this cycle (registered strobe/address) enters the pipe.
    pv_d[0] = rd_q;
    pw_d[0] = addr_q[3:2];
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pw_d[i] = pw_q[i-1];
    end

    if (cap_hit) begin
      dw_d[cap_word] = mem_rdata;
      cap_d          = cap_q + IDX_W'(1);
`ifdef CRITICAL_WORD_FIRST_EN
      // First return of the refill is the critical word.
      if (cap_q == '0) begin
        cv_d = 1'b1;
        cd_d = mem_rdata;
      end
`endif
    end

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          state_d = ISSUE;
          idx_d   = '0;
          cap_d   = '0;
          base_d  = miss_addr[ADDR_WIDTH-1:4];
`ifdef CRITICAL_WORD_FIRST_EN
          start_d = miss_addr[3:2];
`endif
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = WAIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      WAIT: begin
        if (cap_hit && (cap_q == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Word order: wraps from the missed word, or fixed 0..3.
`ifdef CRITICAL_WORD_FIRST_EN
    word_d = start_d + idx_d;
`else
    word_d = idx_d;
`endif

    // Outputs are a registered image of the next state.
    busy_d = (state_d != IDLE);
    rd_d   = (state_d == ISSUE);
    rv_d   = (state_d == DONE);
    // base is 16-byte aligned, so concatenating the offset cannot carry.
    if (state_d == ISSUE) begin
      addr_d = {base_d, word_d, 2'b00};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      rv_q    <= 1'b0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        pv_q[i] <= 1'b0;
        pw_q[i] <= '0;
      end
      for (int unsigned i = 0; i < WORDS; i++) begin
        dw_q[i] <= '0;
      end
`ifdef CRITICAL_WORD_FIRST_EN
      start_q <= '0;
      cv_q    <= 1'b0;
      cd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      rv_q    <= rv_d;
      pv_q    <= pv_d;
      pw_q    <= pw_d;
      dw_q    <= dw_d;
`ifdef CRITICAL_WORD_FIRST_EN
      start_q <= start_d;
      cv_q    <= cv_d;
      cd_q    <= cd_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign mem_rd_en    = rd_q;
  assign mem_addr     = addr_q;
  assign refill_valid = rv_q;
  assign d0           = dw_q[0];
  assign d1           = dw_q[1];
  assign d2           = dw_q[2];
  assign d3           = dw_q[3];
`ifdef CRITICAL_WORD_FIRST_EN
  assign crit_valid   = cv_q;
  assign crit_data    = cd_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Runs two refill engines side by side (memory latency 1 and 3) from a
//   shared directed sequence. Expected read addresses, blocks and critical
//   words are queued when a miss is driven and popped as the engines emit
//   them; per-cycle timing of busy/mem_rd_en/refill_valid is checked inline.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req1  = 1'b0;
  logic        req3  = 1'b0;
  logic [31:0] maddr = '0;

  logic        busy1, rd1, rv1, busy3, rd3, rv3;
  logic [31:0] ma1, ma3, rdata1, rdata3;
  logic [31:0] dd1 [4];
  logic [31:0] dd3 [4];
`ifdef CRITICAL_WORD_FIRST_EN
  logic        cv1, cv3;
  logic [31:0] cd1, cd3;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  q_addr1 [$];
  logic [31:0]  q_addr3 [$];
  logic [127:0] q_blk1  [$];
  logic [127:0] q_blk3  [$];
  logic [31:0]  q_crit1 [$];
  logic [31:0]  q_crit3 [$];

  always #5 clk = ~clk;

  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .miss_req(req1), .miss_addr(maddr), .busy(busy1),
    .mem_rd_en(rd1), .mem_addr(ma1), .mem_rdata(rdata1),
    .d0(dd1[0]), .d1(dd1[1]), .d2(dd1[2]), .d3(dd1[3]), .refill_valid(rv1)
`ifdef CRITICAL_WORD_FIRST_EN
    , .crit_valid(cv1), .crit_data(cd1)
`endif
  );

  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .miss_req(req3), .miss_addr(maddr), .busy(busy3),
    .mem_rd_en(rd3), .mem_addr(ma3), .mem_rdata(rdata3),
    .d0(dd3[0]), .d1(dd3[1]), .d2(dd3[2]), .d3(dd3[3]), .refill_valid(rv3)
`ifdef CRITICAL_WORD_FIRST_EN
    , .crit_valid(cv3), .crit_data(cd3)
`endif
  );

  // Memory contents: 0x100..0x10C hold 0xA0..0xA3, elsewhere address-derived.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + 32'(a[3:2]);
    return {a[31:2], 2'b00} ^ 32'hC3C3_0000;
  endfunction

  // Memory models: latency 1 and latency 3 read pipes.
  logic        sv1 = 1'b0;
  logic [31:0] sa1 = '0;
  logic        sv3 [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] sa3 [3] = '{32'h0, 32'h0, 32'h0};

  always @(posedge clk) begin
    sv1    <= rd1;
    sa1    <= ma1;
    sv3[0] <= rd3;
    sa3[0] <= ma3;
    sv3[1] <= sv3[0];
    sa3[1] <= sa3[0];
    sv3[2] <= sv3[1];
    sa3[2] <= sa3[1];
  end

  assign rdata1 = sv1    ? memval(sa1)    : 32'hDEAD_BEEF;
  assign rdata3 = sv3[2] ? memval(sa3[2]) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic unexpected(input string tag, input logic [127:0] obs);
    checks++;
    errors++;
    $error("FAIL %s observed=%0h expected=nothing", tag, obs);
  endtask

  // Scoreboard push for one miss, both engines.
  task automatic push_exp(input logic [31:0] a);
    logic [31:0] b;
    logic [1:0]  w;
    logic [127:0] blk;
    b = {a[31:4], 4'h0};
    for (int i = 0; i < 4; i++) begin
`ifdef CRITICAL_WORD_FIRST_EN
      w = a[3:2] + 2'(i);
`else
      w = 2'(i);
`endif
      q_addr1.push_back({b[31:4], w, 2'b00});
      q_addr3.push_back({b[31:4], w, 2'b00});
    end
    blk = {memval(b | 32'hC), memval(b | 32'h8), memval(b | 32'h4), memval(b)};
    q_blk1.push_back(blk);
    q_blk3.push_back(blk);
    q_crit1.push_back(memval({b[31:4], a[3:2], 2'b00}));
    q_crit3.push_back(memval({b[31:4], a[3:2], 2'b00}));
  endtask

  // Output monitor: pops expectations as the engines produce reads and blocks.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd1) begin
        if (q_addr1.size() == 0) unexpected("L1_addr", 128'(ma1));
        else check("L1_addr", 128'(ma1), 128'(q_addr1.pop_front()));
      end
      if (rd3) begin
        if (q_addr3.size() == 0) unexpected("L3_addr", 128'(ma3));
        else check("L3_addr", 128'(ma3), 128'(q_addr3.pop_front()));
      end
      if (rv1) begin
        if (q_blk1.size() == 0) unexpected("L1_blk", {dd1[3], dd1[2], dd1[1], dd1[0]});
        else check("L1_blk", {dd1[3], dd1[2], dd1[1], dd1[0]}, q_blk1.pop_front());
      end
      if (rv3) begin
        if (q_blk3.size() == 0) unexpected("L3_blk", {dd3[3], dd3[2], dd3[1], dd3[0]});
        else check("L3_blk", {dd3[3], dd3[2], dd3[1], dd3[0]}, q_blk3.pop_front());
      end
`ifdef CRITICAL_WORD_FIRST_EN
      if (cv1) begin
        if (q_crit1.size() == 0) unexpected("L1_crit", 128'(cd1));
        else check("L1_crit", 128'(cd1), 128'(q_crit1.pop_front()));
      end
      if (cv3) begin
        if (q_crit3.size() == 0) unexpected("L3_crit", 128'(cd3));
        else check("L3_crit", 128'(cd3), 128'(q_crit3.pop_front()));
      end
`endif
    end
  end

  function automatic bit in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Cycle c counts from 1 after the accepting edge; chain adds a second refill
  // accepted in the idle cycle right after the first refill_valid.
  task automatic chk_cyc(input string nm, input int c, input int lat, input bit chain,
                         input logic b, input logic r, input logic v);
    bit eb, er, ev;
    eb = in_rng(c, 1, 5 + lat) || (chain && in_rng(c, 7 + lat, 11 + 2 * lat));
    er = in_rng(c, 1, 4)       || (chain && in_rng(c, 7 + lat, 10 + lat));
    ev = (c == 5 + lat)        || (chain && (c == 11 + 2 * lat));
    check($sformatf("%s_busy_c%0d", nm, c), 128'(b), 128'(eb));
    check($sformatf("%s_rden_c%0d", nm, c), 128'(r), 128'(er));
    check($sformatf("%s_rv_c%0d", nm, c), 128'(v), 128'(ev));
  endtask

  task automatic refill(input logic [31:0] a, input bit chain, input logic [31:0] a2);
    int n1;
    int n3;
    int want;
    n1   = 0;
    n3   = 0;
    want = chain ? 2 : 1;
    @(negedge clk);
    maddr = a;
    req1  = 1'b1;
    req3  = 1'b1;
    push_exp(a);
    if (chain) push_exp(a2);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (chain && c == 2) maddr = a2;
      chk_cyc("L1", c, 1, chain, busy1, rd1, rv1);
      chk_cyc("L3", c, 3, chain, busy3, rd3, rv3);
`ifdef CRITICAL_WORD_FIRST_EN
      check($sformatf("L1_cv_c%0d", c), 128'(cv1), 128'((c == 3) || (chain && c == 10)));
      check($sformatf("L3_cv_c%0d", c), 128'(cv3), 128'((c == 5) || (chain && c == 14)));
`endif
      if (rv1) begin
        n1++;
        if (n1 == want) req1 = 1'b0;
      end
      if (rv3) begin
        n3++;
        if (n3 == want) req3 = 1'b0;
      end
    end
    check("L1_nrv", 128'(n1), 128'(want));
    check("L3_nrv", 128'(n3), 128'(want));
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_L1_ctl"}, 128'({busy1, rd1, rv1}), 128'(0));
    check({nm, "_L3_ctl"}, 128'({busy3, rd3, rv3}), 128'(0));
    check({nm, "_L1_addr"}, 128'(ma1), 128'(0));
    check({nm, "_L3_addr"}, 128'(ma3), 128'(0));
    check({nm, "_L1_d"}, {dd1[3], dd1[2], dd1[1], dd1[0]}, 128'(0));
    check({nm, "_L3_d"}, {dd3[3], dd3[2], dd3[1], dd3[0]}, 128'(0));
`ifdef CRITICAL_WORD_FIRST_EN
    check({nm, "_L1_crit"}, 128'({cv1, cd1}), 128'(0));
    check({nm, "_L3_crit"}, 128'({cv3, cd3}), 128'(0));
`endif
  endtask

  task automatic reset_mid(input logic [31:0] a);
    @(negedge clk);
    maddr = a;
    req1  = 1'b1;
    req3  = 1'b1;
    push_exp(a);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    q_addr1.delete();
    q_addr3.delete();
    q_blk1.delete();
    q_blk3.delete();
    q_crit1.delete();
    q_crit3.delete();
    req1 = 1'b0;
    req3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("postrst_L1_c%0d", c), 128'({busy1, rv1}), 128'(0));
      check($sformatf("postrst_L3_c%0d", c), 128'({busy3, rv3}), 128'(0));
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk_zero("init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    refill(32'h0000_0104, 1'b0, 32'h0);
    refill(32'h0000_0104, 1'b1, 32'h0000_0200);
    reset_mid(32'h0000_0100);
    refill(32'h0000_0300, 1'b0, 32'h0);
    refill(32'h0000_010B, 1'b0, 32'h0);
    refill(32'hFFFF_FFF4, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    check("queues_drained",
          128'(q_addr1.size() + q_addr3.size() + q_blk1.size() + q_blk3.size()), 128'(0));
`ifdef CRITICAL_WORD_FIRST_EN
    check("crit_drained", 128'(q_crit1.size() + q_crit3.size()), 128'(0));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
